// File: rtl/turbo_itl_sched.sv
// turbo_itl_sched: PB job FIFO and launch sequencer for the turbo_rx
// interleaver/deinterleaver datapath (start/feed/wait/gap per job).
module turbo_itl_sched #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned GAP_CYC     = 5,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic                        job_valid,
   output logic                        job_ready,
   input  logic [11:0]                 job_len,
   input  logic [11:0]                 job_offset,
   input  logic                        job_mode,
   output logic                        tr_start,
   output logic                        tr_din_vld,
   output logic [11:0]                 tr_pb_len,
   output logic [11:0]                 tr_pb_offset,
   output logic                        tr_mod_int_dint,
   input  logic                        tr_dout_vld,
   output logic                        done,
   output logic                        err,
   output logic [1:0]                  err_code,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GW = $clog2(GAP_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FEED,
      S_WAIT,
      S_GAP
   } state_t;

   typedef struct packed {
      logic        mode;
      logic [11:0] offset;
      logic [11:0] len;
   } job_t;

   job_t          fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   job_t          head;
   logic          len_ok;

   state_t        state;
   logic [9:0]    beats;
   logic [9:0]    feed_cnt;
   logic [9:0]    out_cnt;
   logic [9:0]    out_cnt_nxt;
   logic [TW-1:0] wait_cnt;
   logic [GW-1:0] gap_cnt;

   assign job_ready = (fifo_level != LW'(FIFO_DEPTH));
   assign push      = job_valid & job_ready;
   assign pop       = (state == S_LOAD);
   assign head      = fifo_mem[rd_ptr];
   assign len_ok    = (head.len != 12'd0) && (head.len[1:0] == 2'b00);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{mode: job_mode, offset: job_offset, len: job_len};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Output beats count from the first FEED cycle and saturate at beats.
   always_comb begin
      out_cnt_nxt = out_cnt;
      if (((state == S_FEED) || (state == S_WAIT)) && tr_dout_vld && (out_cnt != beats))
         out_cnt_nxt = out_cnt + 10'd1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state           <= S_IDLE;
         beats           <= '0;
         feed_cnt        <= '0;
         out_cnt         <= '0;
         wait_cnt        <= '0;
         gap_cnt         <= '0;
         tr_start        <= 1'b0;
         tr_din_vld      <= 1'b0;
         tr_pb_len       <= '0;
         tr_pb_offset    <= '0;
         tr_mod_int_dint <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         err_code        <= '0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
         out_cnt  <= out_cnt_nxt;
         case (state)
            S_IDLE: begin
               if ((fifo_level != '0) || push)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               tr_pb_len       <= head.len;
               tr_pb_offset    <= head.offset;
               tr_mod_int_dint <= head.mode;
               if (!len_ok) begin
                  err      <= 1'b1;
                  err_code <= 2'b01;
                  state    <= S_IDLE;
               end else begin
                  beats      <= head.len[11:2];
                  feed_cnt   <= head.len[11:2];
                  out_cnt    <= '0;
                  tr_start   <= 1'b1;
                  tr_din_vld <= 1'b1;
                  state      <= S_FEED;
               end
            end
            S_FEED: begin
               tr_start <= 1'b0;
               if (feed_cnt == 10'd1) begin
                  tr_din_vld <= 1'b0;
                  wait_cnt   <= '0;
                  state      <= S_WAIT;
               end else begin
                  feed_cnt <= feed_cnt - 10'd1;
               end
            end
            S_WAIT: begin
               if (out_cnt_nxt == beats) begin
                  done    <= 1'b1;
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  err      <= 1'b1;
                  err_code <= 2'b10;
                  gap_cnt  <= '0;
                  state    <= S_GAP;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            // done/err land in the first GAP cycle; GAP_CYC quiet cycles follow it,
            // giving the next tr_start GAP_CYC+3 cycles after done.
            S_GAP: begin
               if (gap_cnt == GW'(GAP_CYC))
                  state <= S_IDLE;
               else
                  gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/turbo_itl_sched.md
Name: turbo_itl_sched

Overview:
Job sequencer for the turbo_rx interleaver/deinterleaver datapath.
- Accepts physical-block (PB) jobs (offset, length, mode) from the upstream MAC/PHY control into a small FIFO.
- Launches jobs one at a time: drives turbo_rx start/din_vld/pb_len/pb_offset/mod_int_dint.
- Tracks dout_vld to detect completion, enforces an inter-job gap, and reports done/error.

Parameters:
FIFO_DEPTH, 4, job FIFO entries (power of 2, ≥2)
GAP_CYC, 5, idle cycles between end of one job and start of the next (≥1)
TIMEOUT_CYC, 4096, max cycles in WAIT before declaring timeout

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
job_valid  in  1  job request valid
job_ready  out  1  FIFO not full; job accepted when job_valid&job_ready
job_len  in  12  PB length in 2-bit symbols
job_offset  in  12  PB base address in turbo_rx buffer
job_mode  in  1  1=interleave, 0=deinterleave
tr_start  out  1  one-cycle start pulse to turbo_rx
tr_din_vld  out  1  input-valid window to turbo_rx
tr_pb_len  out  12  registered job length to turbo_rx
tr_pb_offset  out  12  registered job offset to turbo_rx
tr_mod_int_dint  out  1  registered mode to turbo_rx
tr_dout_vld  in  1  turbo_rx output beat valid
done  out  1  one-cycle pulse, job completed normally
err  out  1  one-cycle pulse, illegal length or timeout
err_code  out  2  valid with err: 01 illegal length, 10 timeout
busy  out  1  state != IDLE
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async, n_rst=0): FIFO empty, state IDLE, all outputs 0 except job_ready=1.
- Reset mid-job: immediate abort, no done/err. FIFO contents are lost.
- FIFO: push on job_valid&job_ready; pop only in LOAD. Simultaneous push and pop when full: push is refused (job_ready already 0); level decrements.
- beats = job_len>>2. Legal length: job_len!=0 and job_len[1:0]==0.
- IDLE: if FIFO non-empty, go to LOAD.
- LOAD (1 cycle): pop head and latch len/offset/mode into tr_pb_len/tr_pb_offset/tr_mod_int_dint. These hold until the next LOAD.
  - Illegal length: err=1, err_code=01, return to IDLE. No start is issued.
  - Otherwise load beat counters and go to FEED.
- FEED: tr_din_vld=1 for exactly beats cycles. tr_start=1 on the first FEED cycle only. After the last beat, go to WAIT.
- Output counter: counts tr_dout_vld beats from the first FEED cycle onward (overlap allowed). Saturates at beats; excess beats are ignored.
- WAIT: tr_din_vld=0.
  - Output count == beats (including a match in the same cycle as entry): done=1 for one cycle, go to GAP.
  - Wait counter reaches TIMEOUT_CYC (counted from WAIT entry): err=1, err_code=10, go to GAP.
- GAP: GAP_CYC cycles with all tr_* strobes 0, then IDLE.
- Back-to-back latency: next tr_start occurs GAP_CYC+3 cycles after done (GAP, IDLE, LOAD, FEED).
- Latency, empty FIFO and IDLE: job accepted at cycle N → LOAD at N+1 → tr_start/first tr_din_vld at N+2.
- done and err never assert in the same cycle.
- busy=1 in LOAD, FEED, WAIT and GAP.
- Counters: 10-bit beats and 13-bit timeout. No wrap is possible within legal ranges.

Test Plan:
1. Reset; push job len=0x040, off=0, mode=1 at cycle N → tr_start at N+2; tr_din_vld high 16 cycles; tr_pb_len=0x040. Model returns 16 dout beats → done pulse once; busy falls GAP_CYC+1 cycles after done.
2. Push len=0x040 then len=0x220 back-to-back → second tr_start exactly 8 cycles after first done; tr_din_vld high 136 cycles; tr_pb_len switches only at second LOAD.
3. Push len=0x000 then len=0x042 → two err pulses with err_code=01; no tr_start; FIFO empties; busy toggles only through LOAD.
4. Push len=0x040, model returns only 10 dout beats → err with err_code=10 exactly TIMEOUT_CYC cycles after WAIT entry; no done; next queued job still launches.
5. Hold job_valid=1 with 6 jobs while the first runs → job_ready=0 once fifo_level=4; all 6 complete in order, with offsets matching tr_pb_offset sequence.
6. Assert n_rst=0 mid-FEED of len=0x220 → tr_din_vld/tr_start drop to 0 immediately; fifo_level=0; no done/err after release.
